// File: rtl/triangle_store.sv
// ============================================================================
// Module   : triangle_store
// Brief    : Triangle scene memory with valid/ready write port, fixed
//            2-cycle read pipeline and a one-entry-per-cycle clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module triangle_store #(
  parameter int NUM_TRIANGLES = 16,
  parameter int ADDR_W        = $clog2(NUM_TRIANGLES),
  parameter int TRI_W         = 288
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [TRI_W-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              mem_ready,
  output logic [TRI_W-1:0]  rd_data,
  output logic              rd_hit,
  output logic [ADDR_W:0]   tri_count,
  output logic              clearing
);

  localparam logic [ADDR_W:0]   c_num_entries = NUM_TRIANGLES[ADDR_W:0];
  localparam logic [ADDR_W-1:0] c_last_idx    = ADDR_W'(NUM_TRIANGLES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_W-1:0]       r_sweep_idx;
  logic [NUM_TRIANGLES-1:0] r_valid;
  logic [ADDR_W:0]         r_tri_count;
  logic                    r_addr_err;
  logic                    r_s1_hit;
  logic [TRI_W-1:0]        r_s1_data;
  logic [TRI_W-1:0]        r_mem [NUM_TRIANGLES];

  logic                    w_wr_fire;
  logic                    w_wr_in_range;
  logic                    w_wr_commit;
  logic                    w_rd_in_range;
  logic                    w_rd_valid;
  logic                    w_rd_take;

  // Next state and ready outputs; a clr pulse closes both ports in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    mem_ready   = 1'b0;
    clearing    = 1'b0;
    case (r_state)
      S_IDLE: begin
        wr_ready  = !clr;
        mem_ready = !clr && !wr_valid;
        if (clr) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clearing = 1'b1;
        if (!clr && (r_sweep_idx == c_last_idx)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr_fire     = wr_valid && wr_ready;
  assign w_wr_in_range = ({1'b0, wr_addr} < c_num_entries);
  assign w_wr_commit   = w_wr_fire && w_wr_in_range;
  assign w_rd_in_range = ({1'b0, rd_addr} < c_num_entries);
  assign w_rd_valid    = w_rd_in_range && r_valid[rd_addr];
  assign w_rd_take     = mem_ready && w_rd_valid;
  assign tri_count     = r_tri_count;

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (clearing) begin
      r_mem[r_sweep_idx] <= '0;
    end else if (w_wr_commit) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sweep_idx <= '0;
      r_valid     <= '0;
      r_tri_count <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (clr) begin
        r_sweep_idx <= '0;
      end else if (clearing) begin
        r_sweep_idx <= r_sweep_idx + 1'b1;
      end

      if (clearing) begin
        r_valid[r_sweep_idx] <= 1'b0;
      end else if (w_wr_commit) begin
        r_valid[wr_addr] <= 1'b1;
      end

      // Only a first write to an entry adds to the population count.
      if (clr) begin
        r_tri_count <= '0;
      end else if (w_wr_commit && !r_valid[wr_addr]) begin
        r_tri_count <= r_tri_count + 1'b1;
      end

      if (w_wr_fire && !w_wr_in_range) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  // Two-stage read pipeline; idle or stalled slots carry zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_hit  <= 1'b0;
      r_s1_data <= '0;
      rd_hit    <= 1'b0;
      rd_data   <= '0;
    end else begin
      r_s1_hit  <= w_rd_take;
      r_s1_data <= w_rd_take ? r_mem[rd_addr] : '0;
      rd_hit    <= r_s1_hit;
      rd_data   <= r_s1_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_triangle_store.sv
// ============================================================================
// Module   : tb_triangle_store
// Brief    : Directed, table-driven self-checking bench for triangle_store.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_triangle_store;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int TW = 288;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [TW-1:0] wr_data;
  logic          wr_ready;
  logic          clr;
  logic [AW-1:0] rd_addr;
  logic          mem_ready;
  logic [TW-1:0] rd_data;
  logic          rd_hit;
  logic [AW:0]   tri_count;
  logic          clearing;

  int total;
  int bad;

  triangle_store #(
    .NUM_TRIANGLES(N),
    .ADDR_W       (AW),
    .TRI_W        (TW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .clr      (clr),
    .rd_addr  (rd_addr),
    .mem_ready(mem_ready),
    .rd_data  (rd_data),
    .rd_hit   (rd_hit),
    .tri_count(tri_count),
    .clearing (clearing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [TW-1:0] wd;
    logic          cl;
    logic [AW-1:0] ra;
    logic          e_wrdy;
    logic          e_mrdy;
    logic          e_hit;
    logic [TW-1:0] e_data;
    logic [AW:0]   e_cnt;
    logic          e_clring;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic wv, input int wa, input logic [TW-1:0] wd,
                              input logic cl, input int ra, input logic e_wrdy,
                              input logic e_mrdy, input logic e_hit,
                              input logic [TW-1:0] e_data, input int e_cnt,
                              input logic e_clring);
    vec_t v;
    v.wv = wv; v.wa = AW'(wa); v.wd = wd; v.cl = cl; v.ra = AW'(ra);
    v.e_wrdy = e_wrdy; v.e_mrdy = e_mrdy; v.e_hit = e_hit; v.e_data = e_data;
    v.e_cnt = (AW+1)'(e_cnt); v.e_clring = e_clring;
    return v;
  endfunction

  function automatic logic [TW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(i);
    return {9{w}};
  endfunction

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input int wa, input logic [TW-1:0] wd,
                       input logic cl, input int ra);
    wr_valid = wv;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    clr      = cl;
    rd_addr  = AW'(ra);
  endtask

  logic [TW-1:0] a_val;
  logic [TW-1:0] b_val;
  int            n_clr;

  initial begin
    total = 0;
    bad   = 0;
    a_val = {36{8'h11}};
    b_val = {36{8'h22}};
    rst_n = 1'b0;
    drive(1'b0, 0, '0, 1'b0, 0);

    // Columns: wv wa data clr ra | wr_ready mem_ready rd_hit rd_data tri_count clearing
    vecs[0]  = mk(0, 0, '0,    0, 0, 1, 1, 0, '0,    0, 0);
    vecs[1]  = mk(1, 3, a_val, 0, 0, 1, 0, 0, '0,    0, 0);
    vecs[2]  = mk(0, 0, '0,    0, 3, 1, 1, 0, '0,    1, 0);
    vecs[3]  = mk(0, 0, '0,    0, 0, 1, 1, 0, '0,    1, 0);
    vecs[4]  = mk(1, 5, b_val, 0, 3, 1, 0, 1, a_val, 1, 0);
    vecs[5]  = mk(0, 0, '0,    0, 3, 1, 1, 0, '0,    2, 0);
    vecs[6]  = mk(1, 3, b_val, 0, 3, 1, 0, 0, '0,    2, 0);
    vecs[7]  = mk(0, 0, '0,    0, 3, 1, 1, 1, a_val, 2, 0);
    vecs[8]  = mk(0, 0, '0,    0, 5, 1, 1, 0, '0,    2, 0);
    vecs[9]  = mk(0, 0, '0,    0, 0, 1, 1, 1, b_val, 2, 0);
    vecs[10] = mk(0, 0, '0,    0, 0, 1, 1, 1, b_val, 2, 0);
    vecs[11] = mk(0, 0, '0,    0, 0, 1, 1, 0, '0,    2, 0);

    // Reset state while rst_n is held low
    #12;
    chk("rst_tri_count", TW'(tri_count), '0);
    chk("rst_rd_hit",    TW'(rd_hit),    '0);
    chk("rst_rd_data",   rd_data,        '0);
    chk("rst_clearing",  TW'(clearing),  '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write/read, stall under write, rewrite, read-after-write
    for (int i = 0; i < 12; i++) begin
      tick();
      drive(vecs[i].wv, int'(vecs[i].wa), vecs[i].wd, vecs[i].cl, int'(vecs[i].ra));
      #1;
      chk($sformatf("v%0d_wr_ready", i),  TW'(wr_ready),  TW'(vecs[i].e_wrdy));
      chk($sformatf("v%0d_mem_ready", i), TW'(mem_ready), TW'(vecs[i].e_mrdy));
      chk($sformatf("v%0d_rd_hit", i),    TW'(rd_hit),    TW'(vecs[i].e_hit));
      chk($sformatf("v%0d_rd_data", i),   rd_data,        vecs[i].e_data);
      chk($sformatf("v%0d_tri_count", i), TW'(tri_count), TW'(vecs[i].e_cnt));
      chk($sformatf("v%0d_clearing", i),  TW'(clearing),  TW'(vecs[i].e_clring));
    end

    // Streaming: fill all entries, then read them back-to-back
    for (int i = 0; i < N; i++) begin
      tick();
      drive(1'b1, i, pat(i), 1'b0, 0);
      #1;
      chk($sformatf("fill%0d_wr_ready", i), TW'(wr_ready), TW'(1'b1));
    end
    for (int j = 0; j < N + 2; j++) begin
      tick();
      drive(1'b0, 0, '0, 1'b0, (j < N) ? j : 0);
      #1;
      if (j == 0) chk("fill_tri_count", TW'(tri_count), TW'(N));
      if (j < N) chk($sformatf("stream%0d_mem_ready", j), TW'(mem_ready), TW'(1'b1));
      if (j >= 2) begin
        chk($sformatf("stream%0d_rd_hit", j - 2),  TW'(rd_hit), TW'(1'b1));
        chk($sformatf("stream%0d_rd_data", j - 2), rd_data,     pat(j - 2));
      end
    end

    // Clear sweep with one read still in flight and an ignored write attempt
    tick();
    drive(1'b0, 0, '0, 1'b0, 3);
    tick();
    drive(1'b0, 0, '0, 1'b1, 3);
    #1;
    chk("clr_pulse_wr_ready",  TW'(wr_ready),  '0);
    chk("clr_pulse_mem_ready", TW'(mem_ready), '0);
    for (int k = 0; k < N; k++) begin
      tick();
      drive(k == 0, 7, a_val, 1'b0, 3);
      #1;
      chk($sformatf("clr%0d_clearing", k),  TW'(clearing),  TW'(1'b1));
      chk($sformatf("clr%0d_wr_ready", k),  TW'(wr_ready),  '0);
      chk($sformatf("clr%0d_mem_ready", k), TW'(mem_ready), '0);
      chk($sformatf("clr%0d_tri_count", k), TW'(tri_count), '0);
      if (k == 0) begin
        chk("clr_inflight_rd_hit",  TW'(rd_hit), TW'(1'b1));
        chk("clr_inflight_rd_data", rd_data,     pat(3));
      end
    end
    tick();
    drive(1'b0, 0, '0, 1'b0, 7);
    #1;
    chk("post_clr_clearing",  TW'(clearing),  '0);
    chk("post_clr_mem_ready", TW'(mem_ready), TW'(1'b1));
    tick();
    drive(1'b0, 0, '0, 1'b0, 3);
    tick();
    drive(1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("post_clr_rd7_hit",  TW'(rd_hit), '0);
    chk("post_clr_rd7_data", rd_data,     '0);
    tick();
    #1;
    chk("post_clr_rd3_hit",  TW'(rd_hit),    '0);
    chk("post_clr_rd3_data", rd_data,        '0);
    chk("post_clr_count",    TW'(tri_count), '0);

    // clr during CLEAR restarts the sweep: 5 + 16 clearing cycles
    tick();
    drive(1'b0, 0, '0, 1'b1, 0);
    n_clr = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      drive(1'b0, 0, '0, n_clr == 4, 0);
      #1;
      if (!clearing) break;
      n_clr++;
    end
    clr = 1'b0;
    chk("restart_clear_cycles", TW'(n_clr), TW'(21));

    // Five writes, two reads, then async reset in the middle of a clear
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b1, i, pat(i + 40), 1'b0, 0);
    end
    tick();
    drive(1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("five_tri_count", TW'(tri_count), TW'(5));
    tick();
    drive(1'b0, 0, '0, 1'b0, 1);
    tick();
    drive(1'b0, 0, '0, 1'b1, 0);
    #1;
    chk("pre_rst_rd0_hit",  TW'(rd_hit), TW'(1'b1));
    chk("pre_rst_rd0_data", rd_data,     pat(40));
    tick();
    drive(1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("pre_rst_clearing", TW'(clearing), TW'(1'b1));
    chk("pre_rst_rd1_hit",  TW'(rd_hit),   TW'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_clearing",  TW'(clearing),  '0);
    chk("async_rst_rd_hit",    TW'(rd_hit),    '0);
    chk("async_rst_rd_data",   rd_data,        '0);
    chk("async_rst_tri_count", TW'(tri_count), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("rel_mem_ready", TW'(mem_ready), TW'(1'b1));
    chk("rel_wr_ready",  TW'(wr_ready),  TW'(1'b1));
    tick();
    tick();
    #1;
    chk("rel_rd0_hit",  TW'(rd_hit), '0);
    chk("rel_rd0_data", rd_data,     '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
